pc_sequencer: RTL

Fetch-stage controller that owns the program counter and sequences instruction fetch. It selects the next PC among sequential (PC+4), EX-resolved branch target and ID-decoded jump target, and runs a request/acknowledge handshake with instruction memory. It absorbs hazard-unit stalls with a one-entry skid buffer and generates the IF/ID and ID/EX flush signals. The block sits between the target-address calculators (branch target = PC + offset·4, jump target = {PC[31:28], address, 2'b0}) and the IF/ID pipeline register.

---
 rtl/pc_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC owner and instruction-fetch sequencer.
// Selects next PC (PC+4, branch, jump), runs the imem req/ack
// handshake, absorbs ID stalls with a one-entry skid buffer and
// raises the IF/ID and ID/EX flush strobes.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall                ID cannot accept an instruction this cycle
//   br_taken, br_target  EX-resolved taken branch (pulse) and target
//   j_valid, j_target    ID-decoded j/jal and its target
//   imem_req, imem_addr  fetch request and address
//   imem_ack, imem_data  request retired, fetched instruction
//   if_valid, if_pc,     registered instruction presented to ID
//   if_instr
//   flush_id, flush_ex   combinational pipeline kill strobes

module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        j_valid,
    input  logic [31:0] j_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush_id,
    output logic        flush_ex
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Address of the request being dropped; pc may be
    // overwritten by a redirect while this one is still in flight.
    logic [31:0] drop_addr_q;
    logic [31:0] drop_addr_d;

    logic        skid_valid_q;
    logic        skid_valid_d;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_pc_d;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_instr_d;

    logic        out_valid_q;
    logic        out_valid_d;
    logic [31:0] out_pc_q;
    logic [31:0] out_pc_d;
    logic [31:0] out_instr_q;
    logic [31:0] out_instr_d;

    logic        jump_take;
    logic        redirect;
    logic [31:0] redir_target;
    logic        ack_fire;
    logic        fetch_ok;
    logic [31:0] pc_seq;

    // A stalled ID cannot act on a jump it is holding.
    assign jump_take    = j_valid & ~stall;
    assign redirect     = br_taken | jump_take;
    assign redir_target = br_taken ? br_target : j_target;

    assign flush_id = redirect;
    assign flush_ex = br_taken;

    // A full skid means the next instruction has nowhere to go,
    // so no new request is issued until it drains.
    assign imem_req  = ((state_q == REQ) & ~skid_valid_q)
                     | (state_q == DROP);
    assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

    assign ack_fire = imem_req & imem_ack;
    assign fetch_ok = ack_fire & (state_q == REQ);
    assign pc_seq   = pc_q + 32'd4;

    assign if_valid = out_valid_q;
    assign if_pc    = out_pc_q;
    assign if_instr = out_instr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= 32'd0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= 32'd0;
            out_instr_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
        end
    end

    // Sequencing state and PC selection.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (redirect) begin
                    // Unacked request must be retired before
                    // the target can be fetched.
                    if (imem_req & ~imem_ack) begin
                        state_d     = DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (ack_fire) begin
                    pc_d = pc_seq;
                end
            end
            DROP: begin
                if (ack_fire) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect) begin
            pc_d = redir_target;
        end
    end

    // Output register and skid buffer.
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;

        if (redirect) begin
            skid_valid_d = 1'b0;
            out_valid_d  = 1'b0;
        end else if (~stall) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pc_d     = skid_pc_q;
                out_instr_d  = skid_instr_q;
                skid_valid_d = 1'b0;
            end else if (fetch_ok) begin
                out_valid_d = 1'b1;
                out_pc_d    = pc_q;
                out_instr_d = imem_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (fetch_ok) begin
            if (~out_valid_q) begin
                out_valid_d = 1'b1;
                out_pc_d    = pc_q;
                out_instr_d = imem_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_pc_d    = pc_q;
                skid_instr_d = imem_data;
            end
        end
    end

endmodule
